// File: rtl/char_pixel_shifter.sv
// char_pixel_shifter: serialises one glyph row per character cell into a
// registered RGB pixel stream, applying reverse/blink/hide/cursor/underline.
// Optional feature macro: CHAR_PIXEL_UNDERLINE_EN (underline forcing logic).
module char_pixel_shifter #(
  parameter int unsigned COLOR_W    = 24,
  parameter int unsigned BLINK_BIT  = 4,
  parameter int unsigned CURSOR_BIT = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ld_i,
  input  logic [63:0]        bmp_i,
  input  logic [5:0]         maxScanpix_i,
  input  logic [COLOR_W-1:0] fgcolor_i,
  input  logic [COLOR_W-1:0] bgcolor_i,
  input  logic [3:0]         attr_i,
  input  logic               cursor_i,
  input  logic [5:0]         scanline_i,
  input  logic [5:0]         ulrow_i,
  input  logic               vsync_i,
  output logic [COLOR_W-1:0] rgb_o,
  output logic               pix_o,
  output logic               active_o
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned FCNT_W = 6;

  logic [63:0]        r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_active;
  logic [FCNT_W-1:0]  r_fcnt;
  logic [COLOR_W-1:0] r_fg;
  logic [COLOR_W-1:0] r_bg;
  logic               r_rev;
  logic               r_blink;
  logic               r_hide;
  logic               r_cur;
  logic [COLOR_W-1:0] r_rgb;
  logic               r_pix;
  logic               r_act_o;
  logic               w_p;

`ifdef CHAR_PIXEL_UNDERLINE_EN
  logic               r_ul;
  logic               w_ul_hit;

  // Underline applies when the cell has the attribute and this is the underline scanline
  assign w_ul_hit = attr_i[2] & (scanline_i == ulrow_i);

  // Latch underline decision at load so it holds for the whole cell row
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ul <= 1'b0;
    end else if (ld_i) begin
      r_ul <= w_ul_hit;
    end
  end

  // Only the selected phase bits of the frame counter are consumed
  logic w_unused_fcnt;
  assign w_unused_fcnt = ^r_fcnt;
`else
  // Underline inputs have no function in this build
  logic w_unused_ul;
  assign w_unused_ul = ^{attr_i[2], scanline_i, ulrow_i, r_fcnt};
`endif

  // Frame counter: one step per vsync pulse, wraps naturally at 6 bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fcnt <= '0;
    end else if (vsync_i) begin
      r_fcnt <= r_fcnt + FCNT_W'(1);
    end
  end

  // Cell capture on load; blink/cursor phases sampled here so a cell is stable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fg    <= '0;
      r_bg    <= '0;
      r_rev   <= 1'b0;
      r_blink <= 1'b0;
      r_hide  <= 1'b0;
      r_cur   <= 1'b0;
    end else if (ld_i) begin
      r_fg    <= fgcolor_i;
      r_bg    <= bgcolor_i;
      r_rev   <= attr_i[0];
      r_blink <= attr_i[1] & r_fcnt[BLINK_BIT];
      r_hide  <= attr_i[3];
      r_cur   <= cursor_i & r_fcnt[CURSOR_BIT];
    end
  end

  // Bit walker: load restarts the cell, otherwise count down to pixel 0 then idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift  <= '0;
      r_cnt    <= CNT_W'(63);
      r_active <= 1'b0;
    end else if (ld_i) begin
      r_shift  <= bmp_i;
      r_cnt    <= maxScanpix_i;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == '0) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Pixel select chain: raw, underline, hide, blink, reverse, cursor
  always_comb begin
    w_p = r_shift[r_cnt];
`ifdef CHAR_PIXEL_UNDERLINE_EN
    if (r_ul) begin
      w_p = 1'b1;
    end
`endif
    if (r_hide) begin
      w_p = 1'b0;
    end
    if (r_blink) begin
      w_p = 1'b0;
    end
    if (r_rev) begin
      w_p = ~w_p;
    end
    if (r_cur) begin
      w_p = ~w_p;
    end
  end

  // Output register: pixel colour while active, background gap fill when idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rgb   <= '0;
      r_pix   <= 1'b0;
      r_act_o <= 1'b0;
    end else if (r_active) begin
      r_rgb   <= w_p ? r_fg : r_bg;
      r_pix   <= w_p;
      r_act_o <= 1'b1;
    end else begin
      r_rgb   <= r_bg;
      r_pix   <= 1'b0;
      r_act_o <= 1'b0;
    end
  end

  assign rgb_o    = r_rgb;
  assign pix_o    = r_pix;
  assign active_o = r_act_o;

endmodule
